// File: rtl/regfile_writer.sv
// regfile_writer
//   Fills an 8-entry register file from a valid/ready source stream, then
//   holds it as Full until the reader releases it.
//
//   Parameters
//     DATA_W      width of InData / WriteData
//
//   Ports
//     clk         single clock, rising edge
//     reset       synchronous active-high reset
//     Load        request to start a fill (honoured only while idle)
//     InValid     source presents a word
//     InData      source word
//     InReady     block accepts a word this cycle (combinational, FILL only)
//     WriteEn     register-file write strobe (one cycle after each transfer)
//     WriteReg    register-file write address
//     WriteData   register-file write data
//     Full        all 8 entries written, contents readable
//     Release     reader is done with the contents (honoured only while full)
//     StallCount  (only with REGFILE_WRITER_STALL_CNT_EN) saturating count of
//                 FILL cycles without InValid since the fill started
//
//   Optional feature macro: REGFILE_WRITER_STALL_CNT_EN
module regfile_writer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Load,
    input  logic              InValid,
    input  logic [DATA_W-1:0] InData,
    output logic              InReady,
    output logic              WriteEn,
    output logic [2:0]        WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              Full,
    input  logic              Release
`ifdef REGFILE_WRITER_STALL_CNT_EN
    ,
    output logic [7:0]        StallCount
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    logic [1:0]        state;
    logic [2:0]        wptr;
    logic              xfer;
    logic              vld_p1;
    logic [2:0]        addr_p1;
    logic [DATA_W-1:0] data_p1;

    assign InReady = (state == FILL);
    assign xfer    = InReady & InValid;

    // Stage p0 -> p1: accepted word becomes the registered write
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            addr_p1 <= 3'd0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= xfer;
            if (xfer) begin
                addr_p1 <= wptr;
                data_p1 <= InData;
            end
        end
    end

    // Control: fill sequencing and write pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wptr  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Load) begin
                        state <= FILL;
                        wptr  <= 3'd0;
                    end
                end
                FILL: begin
                    if (xfer) begin
                        // Pointer wraps 7 -> 0 naturally on the last entry.
                        wptr <= wptr + 3'd1;
                        if (wptr == 3'd7) begin
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    // A simultaneous Load is dropped; the reader must see IDLE first.
                    if (Release) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign WriteEn   = vld_p1;
    assign WriteReg  = addr_p1;
    assign WriteData = data_p1;
    assign Full      = (state == FULL);

`ifdef REGFILE_WRITER_STALL_CNT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 8'd0;
        end else if (state == IDLE && Load) begin
            stall_cnt <= 8'd0;
        end else if (state == FILL && !InValid) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign StallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_regfile_writer.sv
module tb_regfile_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0, Load = 1'b0, InValid = 1'b0, Release = 1'b0;
    logic [7:0] InData = 8'd0;
    logic       InReady, WriteEn, Full;
    logic [2:0] WriteReg;
    logic [7:0] WriteData;
`ifdef REGFILE_WRITER_STALL_CNT_EN
    logic [7:0] StallCount;
`endif

    always #5 clk = ~clk;

    regfile_writer #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset), .Load(Load), .InValid(InValid), .InData(InData),
        .InReady(InReady), .WriteEn(WriteEn), .WriteReg(WriteReg),
        .WriteData(WriteData), .Full(Full), .Release(Release)
`ifdef REGFILE_WRITER_STALL_CNT_EN
        , .StallCount(StallCount)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Behavioural model: tracks "idle / filling / holding full", how many
    // entries have been written in the current fill, and the write the
    // register file should see after each edge.
    typedef enum int {M_IDLE, M_FILLING, M_HOLDING} mode_t;
    mode_t      m_mode = M_IDLE;
    int         m_written = 0;
    logic       m_we = 0;
    logic [2:0] m_wr = 0;
    logic [7:0] m_wd = 0;
    int         m_stalls = 0;

    task automatic model_step(input logic r, l, v, input logic [7:0] d, input logic rel);
        if (r) begin
            m_mode = M_IDLE; m_written = 0; m_we = 0; m_wr = 0; m_wd = 0; m_stalls = 0;
            return;
        end
        m_we = (m_mode == M_FILLING) && v;
        if (m_we) begin
            m_wr = 3'(m_written);
            m_wd = d;
        end
        case (m_mode)
            M_IDLE:    if (l) begin m_mode = M_FILLING; m_written = 0; m_stalls = 0; end
            M_FILLING: begin
                if (v) begin
                    m_written++;
                    if (m_written == 8) begin m_written = 0; m_mode = M_HOLDING; end
                end else if (m_stalls < 255) begin
                    m_stalls++;
                end
            end
            M_HOLDING: if (rel) m_mode = M_IDLE;
            default: ;
        endcase
    endtask

    logic rdy_s, rdy_exp;

    // One clock: drive inputs, sample InReady mid-cycle, advance the model at
    // the edge, leave time at edge+1 for output sampling.
    task automatic step(input logic r, l, v, input logic [7:0] d, input logic rel);
        reset = r; Load = l; InValid = v; InData = d; Release = rel;
        @(negedge clk);
        rdy_s   = InReady;
        rdy_exp = (m_mode == M_FILLING);
        @(posedge clk);
        model_step(r, l, v, d, rel);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".InReady"}, 32'(rdy_s), 32'(rdy_exp));
        chk({tag, ".WriteEn"}, 32'(WriteEn), 32'(m_we));
        chk({tag, ".WriteReg"}, 32'(WriteReg), 32'(m_wr));
        chk({tag, ".WriteData"}, 32'(WriteData), 32'(m_wd));
        chk({tag, ".Full"}, 32'(Full), 32'(m_mode == M_HOLDING));
`ifdef REGFILE_WRITER_STALL_CNT_EN
        chk({tag, ".StallCount"}, 32'(StallCount), 32'(m_stalls));
`endif
    endtask

    task automatic fill(input logic [7:0] base, input string tag);
        step(0, 1, 0, 8'h00, 0); chk_model(tag);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, base + 8'(i), 0);
            chk_model(tag);
            chk({tag, ".addr"}, 32'(WriteReg), i);
            chk({tag, ".data"}, 32'(WriteData), 32'(base + 8'(i)));
        end
        chk({tag, ".full"}, 32'(Full), 1);
    endtask

    typedef struct {
        logic       rst, ld, vl;
        logic [7:0] d;
        logic       rel, chk_rdy, rdy, we;
        logic [2:0] wr;
        logic [7:0] wd;
        logic       full;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Reset, Load, eight back-to-back transfers, one hold cycle, Release.
        tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 3'd0, 8'h00, 0};
        tbl[1]  = '{0, 1, 0, 8'h00, 0, 1, 0, 0, 3'd0, 8'h00, 0};
        for (int i = 0; i < 8; i++)
            tbl[2+i] = '{0, 0, 1, 8'(8'h10 + i), 0, 1, 1, 1, 3'(i), 8'(8'h10 + i), (i == 7)};
        tbl[10] = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 3'd7, 8'h17, 1};
        tbl[11] = '{0, 0, 0, 8'h00, 1, 1, 0, 0, 3'd7, 8'h17, 0};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].ld, tbl[i].vl, tbl[i].d, tbl[i].rel);
            if (tbl[i].chk_rdy) chk($sformatf("tbl%0d.InReady", i), 32'(rdy_s), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d.WriteEn", i), 32'(WriteEn), 32'(tbl[i].we));
            chk($sformatf("tbl%0d.WriteReg", i), 32'(WriteReg), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d.WriteData", i), 32'(WriteData), 32'(tbl[i].wd));
            chk($sformatf("tbl%0d.Full", i), 32'(Full), 32'(tbl[i].full));
        end

        // Full with InValid and Load held: nothing is accepted or written.
        fill(8'h20, "holdfill");
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 8'h55, 0); chk_model("hold");
            chk("hold.Full", 32'(Full), 1);
            chk("hold.WriteEn", 32'(WriteEn), 0);
            chk("hold.InReady", 32'(rdy_s), 0);
        end
        step(0, 1, 1, 8'h55, 1); chk_model("release");
        chk("release.Full", 32'(Full), 0);
        step(0, 0, 1, 8'h56, 0); chk_model("postrel");
        chk("postrel.InReady", 32'(rdy_s), 0);

        // Load together with Release in FULL: Load is dropped.
        fill(8'h30, "ldrelfill");
        step(0, 1, 0, 8'h00, 1); chk_model("ldrel");
        chk("ldrel.Full", 32'(Full), 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 8'h77, 0); chk_model("ldrel.idle");
            chk("ldrel.idle.InReady", 32'(rdy_s), 0);
            chk("ldrel.idle.WriteEn", 32'(WriteEn), 0);
        end

        // Reset coinciding with the 5th transfer.
        step(0, 1, 0, 8'h00, 0); chk_model("rst5");
        for (int i = 0; i < 4; i++) begin step(0, 0, 1, 8'h40 + 8'(i), 0); chk_model("rst5"); end
        step(1, 0, 1, 8'h44, 0); chk_model("rst5.reset");
        chk("rst5.WriteEn", 32'(WriteEn), 0);
        chk("rst5.WriteReg", 32'(WriteReg), 0);
        chk("rst5.WriteData", 32'(WriteData), 0);
        chk("rst5.Full", 32'(Full), 0);
        step(0, 0, 1, 8'h45, 0); chk_model("rst5.idle");
        chk("rst5.idle.InReady", 32'(rdy_s), 0);
        step(0, 1, 0, 8'h00, 0); chk_model("rst5.load");
        step(0, 0, 1, 8'h99, 0); chk_model("rst5.first");
        chk("rst5.first.WriteReg", 32'(WriteReg), 0);
        chk("rst5.first.WriteData", 32'(WriteData), 32'h99);
        step(1, 0, 0, 8'h00, 0); chk_model("rst5.clear");

        // Alternating stall/valid fill: 8 stalls, contiguous addresses.
        step(0, 1, 0, 8'h00, 0); chk_model("toggle");
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1'(i % 2), 8'h60 + 8'(i / 2), 0); chk_model("toggle");
            if (i % 2 == 0) chk("toggle.stallWE", 32'(WriteEn), 0);
            else chk("toggle.addr", 32'(WriteReg), i / 2);
        end
        chk("toggle.Full", 32'(Full), 1);
`ifdef REGFILE_WRITER_STALL_CNT_EN
        chk("toggle.StallCount", 32'(StallCount), 8);
`endif
        step(0, 0, 0, 8'h00, 1); chk_model("toggle.rel");

        // Second full fill after a release restarts at address 0.
        fill(8'hA0, "refill");
        step(0, 0, 0, 8'h00, 1); chk_model("refill.rel");

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r, l, v, rel;
            r   = ($urandom_range(0, 99) == 0);
            l   = ($urandom_range(0, 3) == 0);
            v   = ($urandom_range(0, 2) != 0);
            rel = ($urandom_range(0, 5) == 0);
            step(r, l, v, 8'($urandom), rel);
            chk_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
